// File: rtl/delay_arb.sv
// delay_arb: several requesters share one D-stage, W-bit delay pipeline.
//
// A round-robin arbiter picks at most one requester per cycle. The chosen
// word is tagged with its requester index and enters stage 0. Every word
// leaves stage D-1 exactly D unstalled cycles after its grant.
//
// Output backpressure freezes the whole pipeline, the grant and the
// round-robin pointer. Backpressure only applies while the output stage
// holds a valid word, so an empty output never stalls.
//
// Ports:
//   i_clk        clock, rising edge
//   i_reset      synchronous active-high reset
//   i_req        per-requester request
//   i_data       requester data, requester k at [k*W +: W]
//   o_gnt        one-hot combinational grant
//   i_out_ready  consumer ready for the output word
//   o_out_valid  output stage holds a valid word
//   o_out        output data, 0 when not valid
//   o_out_id     requester index of output word, 0 when not valid
//   o_busy       any pipeline stage valid (state only)
//   o_idle       pipeline empty and no request pending
module delay_arb #(
    parameter int D  = 3,
    parameter int W  = 4,
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N-1:0]    i_req,
    input  logic [N*W-1:0]  i_data,
    output logic [N-1:0]    o_gnt,
    input  logic            i_out_ready,
    output logic            o_out_valid,
    output logic [W-1:0]    o_out,
    output logic [IW-1:0]   o_out_id,
    output logic            o_busy,
    output logic            o_idle
);

    logic [D-1:0]  valid_q;
    logic [W-1:0]  data_q [D];
    logic [IW-1:0] tag_q  [D];
    logic [IW-1:0] ptr_q, ptr_d;

    logic          stall;
    logic          found;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          load_valid_d;
    logic [W-1:0]  load_data_d;
    logic [IW-1:0] load_tag_d;

    // Only a valid output word can be held up by the consumer.
    assign stall = valid_q[D-1] & ~i_out_ready;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(ptr_q) + i) % N);
            if (!found && i_req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        o_gnt        = '0;
        ptr_d        = ptr_q;
        load_valid_d = 1'b0;
        load_data_d  = '0;
        load_tag_d   = '0;
        if (!stall && found) begin
            o_gnt[win_idx] = 1'b1;
            ptr_d          = win_idx;
            load_valid_d   = 1'b1;
            load_data_d    = i_data[win_idx*W +: W];
            load_tag_d     = win_idx;
        end
    end

    // Bubbles travel like words so latency stays fixed at D.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_q <= '0;
            ptr_q   <= IW'(N-1);
            for (int j = 0; j < D; j++) begin
                data_q[j] <= '0;
                tag_q[j]  <= '0;
            end
        end else if (!stall) begin
            ptr_q      <= ptr_d;
            valid_q[0] <= load_valid_d;
            data_q[0]  <= load_data_d;
            tag_q[0]   <= load_tag_d;
            for (int j = 1; j < D; j++) begin
                valid_q[j] <= valid_q[j-1];
                data_q[j]  <= data_q[j-1];
                tag_q[j]   <= tag_q[j-1];
            end
        end
    end

    assign o_out_valid = valid_q[D-1];
    assign o_out       = valid_q[D-1] ? data_q[D-1] : '0;
    assign o_out_id    = valid_q[D-1] ? tag_q[D-1]  : '0;
    assign o_busy      = |valid_q;
    assign o_idle      = ~o_busy & ~|i_req;

endmodule

// File: tb/tb_delay_arb.sv
module tb_delay_arb;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [2:0]  i_req;
    logic [11:0] i_data;
    logic        i_out_ready;

    // instance a: D=3, instance b: D=1; both see the same inputs
    logic [2:0] gnt_a, gnt_b;
    logic       v_a, v_b, busy_a, busy_b, idle_a, idle_b;
    logic [3:0] out_a, out_b;
    logic [1:0] id_a, id_b;

    always #5 clk = ~clk;

    delay_arb #(.D(3), .W(4), .N(3), .IW(2)) u_a (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
        .o_gnt(gnt_a), .i_out_ready(i_out_ready), .o_out_valid(v_a),
        .o_out(out_a), .o_out_id(id_a), .o_busy(busy_a), .o_idle(idle_a));

    delay_arb #(.D(1), .W(4), .N(3), .IW(2)) u_b (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
        .o_gnt(gnt_b), .i_out_ready(i_out_ready), .o_out_valid(v_b),
        .o_out(out_b), .o_out_id(id_b), .o_busy(busy_b), .o_idle(idle_b));

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: each in-flight word carries its age in unstalled
    // cycles since grant; it is visible at the output once age equals depth.
    int dep [2] = '{3, 1};
    bit mv   [2][8];
    int md   [2][8];
    int mid  [2][8];
    int mage [2][8];
    int mptr [2];

    int  ev, ed, eid, mbusy, stl, k, c, g, placed;
    int  ag, av, ao, aid, ab, ai;

    initial begin
        for (int u = 0; u < 2; u++) begin
            mptr[u] = 2;
            for (int s = 0; s < 8; s++) mv[u][s] = 0;
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            ev = 0; ed = 0; eid = 0; mbusy = 0;
            for (int s = 0; s < 8; s++) begin
                if (mv[u][s]) begin
                    mbusy = 1;
                    if (mage[u][s] == dep[u]) begin
                        ev = 1; ed = md[u][s]; eid = mid[u][s];
                    end
                end
            end
            stl = (ev != 0) && !i_out_ready;
            k = -1;
            if (stl == 0) begin
                for (int i = 1; i <= 3; i++) begin
                    c = (mptr[u] + i) % 3;
                    if (k < 0 && i_req[c]) k = c;
                end
            end
            g = (k >= 0) ? (1 << k) : 0;

            if (u == 0) begin
                ag = gnt_a; av = v_a; ao = out_a; aid = id_a; ab = busy_a; ai = idle_a;
            end else begin
                ag = gnt_b; av = v_b; ao = out_b; aid = id_b; ab = busy_b; ai = idle_b;
            end
            if (chk_en) begin
                check(u == 0 ? "a_gnt"  : "b_gnt",  ag,  g);
                check(u == 0 ? "a_valid": "b_valid", av, ev);
                check(u == 0 ? "a_out"  : "b_out",  ao,  ed);
                check(u == 0 ? "a_id"   : "b_id",   aid, eid);
                check(u == 0 ? "a_busy" : "b_busy", ab,  mbusy);
                check(u == 0 ? "a_idle" : "b_idle", ai,
                      ((mbusy == 0) && (i_req == 3'b000)) ? 1 : 0);
            end

            if (i_reset) begin
                for (int s = 0; s < 8; s++) mv[u][s] = 0;
                mptr[u] = 2;
            end else if (stl == 0) begin
                for (int s = 0; s < 8; s++) begin
                    if (mv[u][s]) begin
                        if (mage[u][s] == dep[u]) mv[u][s] = 0;
                        else mage[u][s] = mage[u][s] + 1;
                    end
                end
                if (k >= 0) begin
                    placed = 0;
                    for (int s = 0; s < 8; s++) begin
                        if (!mv[u][s] && placed == 0) begin
                            mv[u][s] = 1; mage[u][s] = 1;
                            md[u][s] = int'((i_data >> (k*4)) & 12'hF);
                            mid[u][s] = k;
                            placed = 1;
                        end
                    end
                    mptr[u] = k;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int exp_g [6] = '{1, 2, 4, 1, 2, 4};

    initial begin
        i_reset = 1; i_req = 0; i_data = 0; i_out_ready = 1;
        tick(); tick();
        i_reset = 0;
        chk_en = 1;
        #1;
        check("rst_valid", v_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_out", out_a, 0);
        check("rst_id", id_a, 0);
        for (int i = 0; i < 6; i++) tick();

        // single request from requester 0
        i_req = 3'b001; i_data = 12'h005;
        #1; check("t1_gnt", gnt_a, 1);
        tick(); i_req = 0; i_data = 0;
        #1; check("t6_d1_valid", v_b, 1);
        check("t6_d1_out", out_b, 5);
        check("t1_busy", busy_a, 1);
        check("t1_early", v_a, 0);
        tick(); tick();
        #1; check("t1_valid", v_a, 1);
        check("t1_out", out_a, 5);
        check("t1_id", id_a, 0);
        tick();
        #1; check("t1_after", v_a, 0);
        check("t6_idle", idle_a, 1);
        i_req = 3'b010;
        #1; check("t6_idle_rise", idle_a, 0);
        tick(); i_req = 0;
        for (int i = 0; i < 4; i++) tick();

        // round robin, then stall
        i_reset = 1; tick(); i_reset = 0;
        i_req = 3'b111; i_data = 12'h321;
        for (int i = 0; i < 6; i++) begin
            #1; check("t2_gnt", gnt_a, exp_g[i]);
            if (i == 3) begin
                check("t2_out", out_a, 1);
                check("t2_id", id_a, 0);
            end
            tick();
        end
        i_out_ready = 0;
        for (int i = 0; i < 2; i++) begin
            #1; check("t3_stall_gnt", gnt_a, 0);
            tick();
        end
        i_out_ready = 1; i_req = 0;
        for (int i = 0; i < 6; i++) tick();

        // pointer hold
        i_reset = 1; tick(); i_reset = 0;
        i_req = 3'b010; #1; check("t4_g1", gnt_a, 2);
        tick(); i_req = 3'b101; #1; check("t4_g2", gnt_a, 4);
        tick(); #1; check("t4_g0", gnt_a, 1);
        tick(); i_req = 0;
        for (int i = 0; i < 4; i++) tick();

        // reset mid-flight
        i_req = 3'b111; i_data = 12'h9AB;
        tick(); tick();
        i_reset = 1; tick();
        i_reset = 0; i_req = 0;
        for (int i = 0; i < 4; i++) begin
            #1; check("t5_valid", v_a, 0);
            check("t5_busy", busy_a, 0);
            tick();
        end
        i_req = 3'b101; #1; check("t5_gnt", gnt_a, 1);
        tick(); i_req = 0;
        for (int i = 0; i < 4; i++) tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            i_req       = 3'($urandom_range(0, 7));
            i_data      = 12'($urandom);
            i_out_ready = ($urandom_range(0, 9) < 7);
            i_reset     = ($urandom_range(0, 99) == 0);
            tick();
        end
        i_reset = 0; i_req = 0; i_out_ready = 1;
        for (int i = 0; i < 6; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
